// File: rtl/player_input_tx_if.sv
// Port bundle between the frame-strobe/control side and the serial transmitter.
//   frame_update : one-cycle send request
//   enable       : 1 = requests accepted
//   player_id    : local player ID
//   left/right/up/down/chop/carry : debounced controls
//   tx           : serial line, idle high
//   busy         : packet in flight
//   sent         : one-cycle pulse when a packet completes
//   overrun      : sticky, a request was dropped
// master drives the requests/controls, slave is the transmitter.
interface player_input_tx_if;
  logic       frame_update;
  logic       enable;
  logic [1:0] player_id;
  logic       left;
  logic       right;
  logic       up;
  logic       down;
  logic       chop;
  logic       carry;
  logic       tx;
  logic       busy;
  logic       sent;
  logic       overrun;

  modport master (
    output frame_update, enable, player_id, left, right, up, down, chop, carry,
    input  tx, busy, sent, overrun
  );

  modport slave (
    input  frame_update, enable, player_id, left, right, up, down, chop, carry,
    output tx, busy, sent, overrun
  );
endinterface

// File: rtl/player_input_tx.sv
// Per-frame UART transmitter of the local player's controls.
// Sends a 3-byte packet {SYNC_BYTE, payload, ~payload}, each byte 8N1 LSB first, with
// payload = {player_id, carry, chop, up, down, left, right}.
// Ports:
//   clock   : system clock (25 MHz pixel clock)
//   reset_n : asynchronous active-low reset
//   bus     : player_input_tx_if.slave (requests, controls, tx/busy/sent/overrun)
// Optional feature: define PLAYER_TX_PARITY_EN for 8E1 framing (even parity bit per byte).
module player_input_tx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input logic              clock,
  input logic              reset_n,
  player_input_tx_if.slave bus
);

  localparam int unsigned     CntW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

`ifdef PLAYER_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StDone} state_e;
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      payload_q, payload_d;
  logic            pending_q, pending_d;
  logic            overrun_q, overrun_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            sent_q, sent_d;

  logic       req;
  logic       bit_end;
  logic [7:0] cur_byte;

  assign req     = bus.frame_update & bus.enable;
  assign bit_end = (cnt_q == CntMax);

  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_idx_q)
      2'd1:    cur_byte = payload_q;
      2'd2:    cur_byte = ~payload_q;
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    payload_d  = payload_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;

    // Bit timer runs in every serial state and wraps at the bit boundary.
    if (state_q != StIdle && state_q != StDone) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (req || pending_q) begin
          payload_d  = {bus.player_id, bus.carry, bus.chop, bus.up, bus.down,
                        bus.left, bus.right};
          pending_d  = 1'b0;
          cnt_d      = '0;
          byte_idx_d = 2'd0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          bit_idx_d = 3'd0;
          shift_d   = cur_byte;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef PLAYER_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef PLAYER_TX_PARITY_EN
      StParity: begin
        if (bit_end) state_d = StStop;
      end
`endif
      StStop: begin
        if (bit_end) begin
          if (byte_idx_q != 2'd2) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = StStart;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outside IDLE a request is queued one deep; a second one is dropped.
    if (req && state_q != StIdle) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end
  end

  // Outputs are registered from the next state so the serial pin never glitches.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = 1'b0;
    sent_d = (state_d == StDone);
    case (state_d)
      StStart: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      StData: begin
        tx_d   = shift_d[0];
        busy_d = 1'b1;
      end
`ifdef PLAYER_TX_PARITY_EN
      StParity: begin
        tx_d   = ^cur_byte;
        busy_d = 1'b1;
      end
`endif
      StStop:  busy_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shift_q    <= '0;
      payload_q  <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      sent_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      payload_q  <= payload_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      sent_q     <= sent_d;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.sent    = sent_q;
  assign bus.overrun = overrun_q;

endmodule
